// File: rtl/bomb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bomb_pkg
// Purpose  : Shared state encoding, default constants and a counter-width
//            helper for the time-bomb countdown controller.
// Revision : 1.0 - initial release
// ============================================================================
package bomb_pkg;

  // Controller states, explicitly 3 bits wide
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUNNING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_EXPLODE = 3'd4,
    ST_DEFUSED = 3'd5
  } bomb_state_t;

  // Board clock and the countdown start value shown on the display
  localparam int CLK_FREQ_HZ  = 31_500_000;
  localparam int BOMB_SECONDS = 99;

  // Bits needed to count 0..n-1; a single bit even when n is 1
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Free-running modulo-TICK_DIV counter that emits a registered
//            one-cycle tick each time it wraps. Holds its value while run
//            is low; clear returns it to zero.
// Revision : 1.0 - initial release
// ============================================================================
module tick_prescaler
  import bomb_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int             c_w    = cnt_width(TICK_DIV);
  localparam logic [c_w-1:0] c_last = c_w'(TICK_DIV - 1);

  logic [c_w-1:0] r_cnt;
  logic           r_tick;

  // Count while running, wrap at TICK_DIV-1 and register the wrap as the tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (clear) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (run) begin
      r_cnt  <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
      r_tick <= (r_cnt == c_last);
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/bomb_countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bomb_countdown_ctrl
// Purpose  : Control FSM around the 99->0 BCD countdown counter. Drives the
//            counter load/enable, generates the per-second count tick and
//            produces explode / defused / warning / blink display flags.
// Revision : 1.0 - initial release
// ============================================================================
module bomb_countdown_ctrl
  import bomb_pkg::*;
#(
  parameter int TICK_DIV       = CLK_FREQ_HZ,
  parameter int EXPLODE_CYCLES = 2 * CLK_FREQ_HZ,
  parameter int BLINK_DIV      = CLK_FREQ_HZ / 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arm,
  input  logic       pause,
  input  logic       defuse,
  input  logic [3:0] countL,
  input  logic [3:0] countH,
  input  logic       tc,
  output logic       loadN,
  output logic       enable1,
  output logic       enable2,
  output logic       explode,
  output logic       defused,
  output logic       warning,
  output logic       blink
);

  localparam int            c_ew       = cnt_width(EXPLODE_CYCLES);
  localparam logic [c_ew-1:0] c_exp_last = c_ew'(EXPLODE_CYCLES - 1);

  bomb_state_t     r_state;
  bomb_state_t     w_next;
  logic [c_ew-1:0] r_exp_cnt;

  logic r_loadN;
  logic r_enable2;
  logic r_explode;
  logic r_defused;
  logic r_warning;
  logic r_blink;

  logic w_active_now;
  logic w_active_nxt;
  logic w_warn_nxt;
  logic w_tick_run;
  logic w_tick_clr;
  logic w_tick;
  logic w_blink_tick;

  // The low digit only feeds the display; nothing here depends on it
  logic w_unused_countl;
  assign w_unused_countl = &{1'b0, countL};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state plus the next values of every registered output
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (arm) w_next = ST_LOAD;
      ST_LOAD:    w_next = ST_RUNNING;
      ST_RUNNING: begin
        // Reaching 00 wins over any operator input
        if (tc)          w_next = ST_EXPLODE;
        else if (defuse) w_next = ST_DEFUSED;
        else if (pause)  w_next = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (defuse)     w_next = ST_DEFUSED;
        else if (pause) w_next = ST_RUNNING;
      end
      ST_EXPLODE: if (r_exp_cnt == c_exp_last) w_next = ST_IDLE;
      ST_DEFUSED: if (arm) w_next = ST_LOAD;
      default:    w_next = ST_IDLE;
    endcase

    w_active_now = (r_state == ST_RUNNING) || (r_state == ST_PAUSED);
    w_active_nxt = (w_next  == ST_RUNNING) || (w_next  == ST_PAUSED);
    // Requiring the current state to be active too skips the LOAD cycle,
    // where the counter still shows its previous (possibly < 10) value
    w_warn_nxt   = w_active_now && w_active_nxt && (countH == 4'd0) && !tc;

    // The prescaler only advances in cycles that stay RUNNING, so a pause,
    // defuse or terminal count in this cycle can never register a tick
    w_tick_run   = (r_state == ST_RUNNING) && (w_next == ST_RUNNING);
    w_tick_clr   = (r_state == ST_LOAD);
  end

  // Registered outputs and the explode-duration counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exp_cnt <= '0;
      r_loadN   <= 1'b1;
      r_enable2 <= 1'b0;
      r_explode <= 1'b0;
      r_defused <= 1'b0;
      r_warning <= 1'b0;
      r_blink   <= 1'b0;
    end else begin
      r_exp_cnt <= ((r_state == ST_EXPLODE) && (w_next == ST_EXPLODE)) ?
                   r_exp_cnt + 1'b1 : '0;
      r_loadN   <= (w_next != ST_LOAD);
      r_enable2 <= (w_next == ST_RUNNING);
      r_explode <= (w_next == ST_EXPLODE);
      r_defused <= (w_next == ST_DEFUSED);
      r_warning <= w_warn_nxt;
      r_blink   <= w_warn_nxt ? (r_blink ^ w_blink_tick) : 1'b0;
    end
  end

  // Once-per-second count tick for the counter
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_count_tick (
    .clk   (clk),
    .reset (reset),
    .clear (w_tick_clr),
    .run   (w_tick_run),
    .tick  (w_tick)
  );

  // Blink half-period divider, idle and cleared while no warning is shown
  tick_prescaler #(
    .TICK_DIV (BLINK_DIV)
  ) u_blink_tick (
    .clk   (clk),
    .reset (reset),
    .clear (!r_warning),
    .run   (r_warning),
    .tick  (w_blink_tick)
  );

  assign loadN   = r_loadN;
  assign enable1 = w_tick;
  assign enable2 = r_enable2;
  assign explode = r_explode;
  assign defused = r_defused;
  assign warning = r_warning;
  assign blink   = r_blink;

endmodule
`default_nettype wire
